// File: rtl/sl_wb_pkg.sv
// Shared types and bus widths for the sl_wb Wishbone master bridge.
// Width macros may be predefined by the build; otherwise 32-bit address/data.

`ifndef WB_ADDR_WIDTH
`define WB_ADDR_WIDTH 32
`endif
`ifndef WB_DATA_WIDTH
`define WB_DATA_WIDTH 32
`endif
`ifndef WB_BE_WIDTH
`define WB_BE_WIDTH (`WB_DATA_WIDTH / 8)
`endif

package sl_wb_pkg;

  localparam int unsigned WB_ADDR_W = `WB_ADDR_WIDTH;
  localparam int unsigned WB_DATA_W = `WB_DATA_WIDTH;
  localparam int unsigned WB_BE_W   = `WB_BE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    BACKOFF
  } wb_mst_state_t;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] wdata;
    logic [WB_BE_W-1:0]   be;
  } wb_req_t;

endpackage

// File: rtl/sl_wb_tmo_cnt.sv
// Per-attempt timeout counter for the Wishbone master bridge.
// load_i clears the count, en_i advances it; expire_o flags the last
// enabled cycle of a TIMEOUT_CYCLES-long window.

module sl_wb_tmo_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next count: clear on load, otherwise count enabled cycles up to expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sl_wb_master.sv
// Core-side Wishbone B4 pipelined master bridge: one valid/ready request in,
// one single-beat bus cycle out, one response pulse back. rty is retried up
// to MAX_RETRY times with RETRY_GAP idle cycles in between.
// Optional feature macro: SL_WB_MASTER_TIMEOUT_EN adds a per-attempt abort
// after TIMEOUT_CYCLES bus cycles without a termination.

module sl_wb_master
  import sl_wb_pkg::*;
#(
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic                      req_we,
  input  logic [`WB_ADDR_WIDTH-1:0] req_addr,
  input  logic [`WB_DATA_WIDTH-1:0] req_wdata,
  input  logic [`WB_BE_WIDTH-1:0]   req_be,
  output logic                      resp_val,
  output logic [`WB_DATA_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic                      wb_lock_o,
  output logic                      wb_tga_o,
  output logic                      wb_tgc_o,
  output logic [`WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [`WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic [`WB_BE_WIDTH-1:0]   wb_sel_o,
  input  logic [`WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_stall_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  if (RETRY_GAP < 1 || RETRY_GAP > 15) begin : g_bad_retry_gap
    $error("sl_wb_master: RETRY_GAP must lie in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sl_wb_master: TIMEOUT_CYCLES must be at least 1");
  end

  wb_mst_state_t           state_q, state_d;
  wb_req_t                 req_q, req_d;
  logic [RTY_W-1:0]        retry_q, retry_d;
  logic [3:0]              gap_q, gap_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    rdy_q, rdy_d;
  logic                    resp_val_q, resp_val_d;
  logic                    resp_err_q, resp_err_d;
  logic [WB_DATA_W-1:0]    resp_rdata_q, resp_rdata_d;

  logic                    live;
  logic                    tmo_load;
  logic                    tmo_en;
  logic                    tmo_expire;

  // The strobe is only accepted once stall is low, so terminations count
  // from that cycle onwards; IDLE and BACKOFF ignore them.
  assign live     = (state_q == WAIT) || (state_q == REQ && !wb_stall_i);
  assign tmo_load = (state_q == IDLE && req_val) || (state_q == BACKOFF && gap_q == 4'd0);
  assign tmo_en   = (state_q == REQ) || (state_q == WAIT);

`ifdef SL_WB_MASTER_TIMEOUT_EN
  sl_wb_tmo_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (tmo_load),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );
`else
  logic tmo_unused;
  assign tmo_unused = tmo_load ^ tmo_en;
  assign tmo_expire = 1'b0 & tmo_unused;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    logic resp_now;
    logic resp_fail;
    state_d      = state_q;
    req_d        = req_q;
    retry_d      = retry_q;
    gap_d        = gap_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    rdy_d        = rdy_q;
    resp_val_d   = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    resp_now     = 1'b0;
    resp_fail    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_val) begin
          req_d   = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
          retry_d = '0;
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      REQ: begin
        if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
      end
      BACKOFF: begin
        if (gap_q == 4'd0) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (live && wb_err_i) begin
      resp_now  = 1'b1;
      resp_fail = 1'b1;
    end else if (live && wb_rty_i) begin
      if (retry_q < RTY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RTY_W'(1);
        gap_d   = 4'(RETRY_GAP - 1);
        state_d = BACKOFF;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end else begin
        resp_now  = 1'b1;
        resp_fail = 1'b1;
      end
    end else if (live && wb_ack_i) begin
      resp_now     = 1'b1;
      resp_rdata_d = req_q.we ? '0 : wb_dat_i;
    end else if (tmo_expire) begin
      resp_now  = 1'b1;
      resp_fail = 1'b1;
    end

    if (resp_now) begin
      resp_val_d = 1'b1;
      resp_err_d = resp_fail;
      state_d    = IDLE;
      cyc_d      = 1'b0;
      stb_d      = 1'b0;
      rdy_d      = 1'b1;
    end
  end

  // State, request latch and output registers; reset aborts any bus cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      retry_q      <= '0;
      gap_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rdy_q        <= 1'b1;
      resp_val_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      retry_q      <= retry_d;
      gap_q        <= gap_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      rdy_q        <= rdy_d;
      resp_val_q   <= resp_val_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_rdy    = rdy_q;
  assign resp_val   = resp_val_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = req_q.we;
  assign wb_adr_o   = req_q.addr;
  assign wb_dat_o   = req_q.wdata;
  assign wb_sel_o   = req_q.be;
  assign wb_lock_o  = 1'b0;
  assign wb_tga_o   = 1'b0;
  assign wb_tgc_o   = 1'b0;

endmodule
